// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file read sequencer: default widths,
// FSM state encoding and a counter-width helper.
package regfile_pkg;

  localparam int unsigned ADDR_W_DEF   = 3;
  localparam int unsigned DATA_W_DEF   = 16;
  localparam int unsigned SCAN_DIV_DEF = 4;

  // State encoding
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SETUP   = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] HOLD    = 2'd3;

  typedef enum logic [1:0] {
    StIdle    = IDLE,
    StSetup   = SETUP,
    StCapture = CAPTURE,
    StHold    = HOLD
  } state_e;

  // Width of a counter that must hold values 0..div-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/regfile_reader_scan_tick.sv
// Auto-scan tick generator: a down-counter reloaded to SCAN_DIV-1 on clear,
// counting while enabled, emitting a 1-cycle tick when it reaches zero.
module scan_tick
  import regfile_pkg::*;
#(
  parameter int unsigned SCAN_DIV = SCAN_DIV_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tick
);

  localparam int unsigned    CntW    = cnt_width(SCAN_DIV);
  localparam logic [CntW-1:0] LoadVal = CntW'(SCAN_DIV - 1);

  logic [CntW-1:0] r_cnt;

  // Counter: reload on clear, count down while enabled, reload after reaching zero
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= LoadVal;
    end else if (i_en) begin
      r_cnt <= (r_cnt == '0) ? LoadVal : r_cnt - 1'b1;
    end
  end

  // Tick on the enabled cycle where the count has run out
  always_comb begin
    o_tick = i_en && !i_clr && (r_cnt == '0);
  end

endmodule

// File: rtl/regfile_reader.sv
// Read-side sequencer for the register file: walks the port-A read address,
// captures each register into a holding register and presents it to the
// display side. Advances on a step pulse (manual) or an internal tick (auto).
// Optional feature macro: READ_CHECKSUM_EN adds a running checksum output.
module regfile_reader
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned SCAN_DIV = SCAN_DIV_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,      // asynchronous, active low
  input  logic              i_start,
  input  logic              i_step,
  input  logic              i_auto,
  input  logic              i_stop,
  output logic [ADDR_W-1:0] o_rd_adrs,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic [ADDR_W-1:0] o_adrs_out,
  output logic [DATA_W-1:0] o_data_out,
  output logic              o_data_valid,
  output logic              o_busy,
  output logic              o_scan_done
`ifdef READ_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] o_chk_sum
`endif
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [ADDR_W-1:0] r_rd_adrs;
  logic [ADDR_W-1:0] r_adrs_out;
  logic [DATA_W-1:0] r_data_out;
  logic              r_data_valid;
  logic              r_scan_done;

  logic w_tick;
  logic w_tick_clr;
  logic w_tick_en;
  logic w_begin;
  logic w_capture;
  logic w_advance;
  logic w_at_max;
  logic w_wrap;

  scan_tick #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan_tick (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (w_tick_clr),
    .i_en   (w_tick_en),
    .o_tick (w_tick)
  );

  // Event decode; stop overrides every other request
  always_comb begin
    w_at_max  = (r_rd_adrs == {ADDR_W{1'b1}});
    w_begin   = (r_state == StIdle) && i_start && !i_stop;
    // Capture happens on the edge leaving SETUP so data is valid throughout CAPTURE
    w_capture = (r_state == StSetup) && !i_stop;
    w_advance = (r_state == StHold) && !i_stop && (i_auto ? w_tick : i_step);
    w_wrap    = w_advance && w_at_max;
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (i_stop) begin
      w_state_nxt = StIdle;
    end else begin
      unique case (r_state)
        StIdle:    if (i_start) w_state_nxt = StSetup;
        StSetup:   w_state_nxt = StCapture;
        StCapture: w_state_nxt = StHold;
        StHold: begin
          if (w_advance) begin
            w_state_nxt = (w_at_max && !i_auto) ? StIdle : StSetup;
          end
        end
        default:   w_state_nxt = StIdle;
      endcase
    end
  end

  // State-decoded outputs and tick-counter control
  always_comb begin
    o_busy     = (r_state != StIdle);
    w_tick_clr = (r_state == StCapture);
    w_tick_en  = (r_state == StHold);
  end

  // Read address, capture registers and strobes
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_rd_adrs    <= '0;
      r_adrs_out   <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_scan_done  <= 1'b0;
    end else begin
      r_data_valid <= w_capture;
      r_scan_done  <= w_wrap;
      if (w_begin) begin
        r_rd_adrs <= '0;
      end else if (w_advance) begin
        // Natural modulo wrap takes the last address back to 0
        r_rd_adrs <= r_rd_adrs + 1'b1;
      end
      if (w_capture) begin
        r_data_out <= i_rd_data;
        r_adrs_out <= r_rd_adrs;
      end
    end
  end

`ifdef READ_CHECKSUM_EN
  logic [DATA_W-1:0] r_chk_sum;
  logic              r_chk_frozen;

  // Checksum: cleared on start, accumulates each capture, frozen after a full pass
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_chk_sum    <= '0;
      r_chk_frozen <= 1'b0;
    end else if (w_begin) begin
      r_chk_sum    <= '0;
      r_chk_frozen <= 1'b0;
    end else begin
      if (w_capture && !r_chk_frozen) begin
        r_chk_sum <= r_chk_sum + i_rd_data;
      end
      if (w_wrap) begin
        r_chk_frozen <= 1'b1;
      end
    end
  end

  assign o_chk_sum = r_chk_sum;
`endif

  assign o_rd_adrs    = r_rd_adrs;
  assign o_adrs_out   = r_adrs_out;
  assign o_data_out   = r_data_out;
  assign o_data_valid = r_data_valid;
  assign o_scan_done  = r_scan_done;

endmodule

// File: tb/tb_regfile_reader.sv
// Scoreboard bench for regfile_reader: stimulus pushes expected captures,
// a negedge monitor pops and compares on every data_valid pulse.
module tb_regfile_reader;
  import regfile_pkg::*;

  localparam int unsigned AW  = 3;
  localparam int unsigned DW  = 16;
  localparam int unsigned DIV = 4;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic          start   = 1'b0;
  logic          step    = 1'b0;
  logic          auto_en = 1'b0;
  logic          stop    = 1'b0;
  logic [AW-1:0] rd_adrs;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] adrs_out;
  logic [DW-1:0] data_out;
  logic          dv;
  logic          busy;
  logic          sd;
`ifdef READ_CHECKSUM_EN
  logic [DW-1:0] chk_sum;
`endif

  logic [DW-1:0] regs [8];

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks    = 0;
  int   n_fail      = 0;
  int   dv_cnt      = 0;
  int   sd_cnt      = 0;
  int   cyc         = 0;
  int   last_dv_cyc = -1;
  bit   period_chk  = 1'b0;
  int   dv0;
  int   sd0;
  logic [DW-1:0] exp_sum;

  regfile_reader #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .SCAN_DIV (DIV)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst_n),
    .i_start      (start),
    .i_step       (step),
    .i_auto       (auto_en),
    .i_stop       (stop),
    .o_rd_adrs    (rd_adrs),
    .i_rd_data    (rd_data),
    .o_adrs_out   (adrs_out),
    .o_data_out   (data_out),
    .o_data_valid (dv),
    .o_busy       (busy),
    .o_scan_done  (sd)
`ifdef READ_CHECKSUM_EN
    ,
    .o_chk_sum    (chk_sum)
`endif
  );

  always #5 clk = ~clk;

  // Combinational register-file read port
  assign rd_data = regs[rd_adrs];

  function automatic logic [DW-1:0] rval(input int n);
    logic [31:0] v;
    v = 32'hBBDD + n * 32'h1010;
    return v[DW-1:0];
  endfunction

  function automatic exp_t mk(input int n);
    exp_t e;
    e.a = AW'(n);
    e.d = rval(n);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    wait_cyc(1);
    start = 1'b0;
  endtask

  task automatic pulse_step();
    step = 1'b1;
    wait_cyc(1);
    step = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    wait_cyc(1);
    stop = 1'b0;
  endtask

  // Cycle counter used for data_valid spacing
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: compare every presented capture against the scoreboard
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (dv) begin
        dv_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL dv_unexpected: got data_valid with adrs %0h data %0h, expected none",
                   adrs_out, data_out);
        end else begin
          mon_e = exp_q.pop_front();
          chk("adrs_out", 32'(adrs_out), 32'(mon_e.a));
          chk("data_out", 32'(data_out), 32'(mon_e.d));
        end
        if (period_chk && last_dv_cyc >= 0) chk("dv_period", cyc - last_dv_cyc, 6);
        last_dv_cyc = cyc;
      end
      if (sd) sd_cnt++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation timeout");
  end

  initial begin
    for (int n = 0; n < 8; n++) regs[n] = rval(n);
    exp_sum = '0;
    for (int n = 0; n < 8; n++) exp_sum = exp_sum + rval(n);

    // 1: reset held 100ns with toggling inputs
    rst_n = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      start   = ~start;
      step    = ~step;
      auto_en = ~auto_en;
      stop    = 1'($urandom_range(0, 1));
    end
    chk("rst_rd_adrs", 32'(rd_adrs), 0);
    chk("rst_adrs_out", 32'(adrs_out), 0);
    chk("rst_data_out", 32'(data_out), 0);
    chk("rst_data_valid", 32'(dv), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_scan_done", 32'(sd), 0);
`ifdef READ_CHECKSUM_EN
    chk("rst_chk_sum", 32'(chk_sum), 0);
`endif
    start = 1'b0; step = 1'b0; auto_en = 1'b0; stop = 1'b0;
    #3 rst_n = 1'b1;
    wait_cyc(1);
    chk("idle_busy", 32'(busy), 0);

    // 2: manual full scan
    exp_q.push_back(mk(0));
    pulse_start();
    chk("start_lat1_dv", 32'(dv), 0);
    wait_cyc(1);
    chk("start_lat2_dv", 32'(dv), 1);
    wait_cyc(1);
    for (int k = 1; k < 8; k++) begin
      exp_q.push_back(mk(k));
      pulse_step();
      wait_cyc(2);
    end
    chk("busy_in_hold", 32'(busy), 1);
    pulse_step();
    chk("scan_done_pulse", 32'(sd), 1);
    chk("busy_after_scan", 32'(busy), 0);
    chk("rd_adrs_wrapped", 32'(rd_adrs), 0);
    wait_cyc(1);
    chk("scan_done_width", 32'(sd), 0);
    chk("manual_dv_count", dv_cnt, 8);
    chk("manual_sd_count", sd_cnt, 1);
`ifdef READ_CHECKSUM_EN
    chk("chk_sum_manual", 32'(chk_sum), 32'(exp_sum));
`endif
    chk("queue_empty_manual", exp_q.size(), 0);

    // 3: auto scan with wrap
    auto_en     = 1'b1;
    period_chk  = 1'b1;
    last_dv_cyc = -1;
    dv0 = dv_cnt;
    sd0 = sd_cnt;
    for (int i = 0; i < 12; i++) exp_q.push_back(mk(i % 8));
    pulse_start();
    for (int c = 0; c < 200 && (dv_cnt - dv0) < 12; c++) wait_cyc(1);
    chk("auto_dv_count", dv_cnt - dv0, 12);
    chk("auto_wraps", sd_cnt - sd0, 1);
    chk("auto_busy", 32'(busy), 1);
`ifdef READ_CHECKSUM_EN
    chk("chk_sum_frozen", 32'(chk_sum), 32'(exp_sum));
`endif
    pulse_stop();
    period_chk = 1'b0;
    auto_en    = 1'b0;
    chk("auto_stop_busy", 32'(busy), 0);
    wait_cyc(2);
    chk("queue_empty_auto", exp_q.size(), 0);

    // 4: stop together with step while in SETUP at address 3
    dv0 = dv_cnt;
    sd0 = sd_cnt;
    for (int k = 0; k < 3; k++) exp_q.push_back(mk(k));
    pulse_start();
    wait_cyc(2);
    pulse_step();
    wait_cyc(2);
    pulse_step();
    wait_cyc(2);
    pulse_step();
    chk("setup_rd_adrs", 32'(rd_adrs), 3);
    stop = 1'b1;
    step = 1'b1;
    wait_cyc(1);
    stop = 1'b0;
    step = 1'b0;
    chk("stop_busy", 32'(busy), 0);
    wait_cyc(3);
    chk("stop_adrs_out", 32'(adrs_out), 2);
    chk("stop_data_out", 32'(data_out), 32'(rval(2)));
    chk("stop_dv_count", dv_cnt - dv0, 3);
    chk("stop_sd_count", sd_cnt - sd0, 0);

    // 5: start during HOLD, step during IDLE
    exp_q.push_back(mk(0));
    pulse_start();
    wait_cyc(2);
    dv0 = dv_cnt;
    pulse_start();
    wait_cyc(3);
    chk("hold_start_busy", 32'(busy), 1);
    chk("hold_start_rd_adrs", 32'(rd_adrs), 0);
    chk("hold_start_no_dv", dv_cnt - dv0, 0);
    exp_q.push_back(mk(1));
    pulse_step();
    wait_cyc(2);
    chk("hold_still_steps", dv_cnt - dv0, 1);
    pulse_stop();
    pulse_step();
    wait_cyc(3);
    chk("idle_step_busy", 32'(busy), 0);
    chk("idle_step_rd_adrs", 32'(rd_adrs), 1);
    chk("idle_step_no_dv", dv_cnt - dv0, 1);
    chk("queue_empty_final", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
